// File: rtl/snn_input_dbuf_if.sv
// rtl/snn_input_dbuf_if.sv - UART byte, image handshake and pixel read port bundle for snn_input_dbuf
interface snn_input_dbuf_if #(
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 10
);
  logic [BYTE_W-1:0] rx_data;
  logic              rx_rdy;
  logic              img_valid;
  logic              img_ack;
  logic              core_done;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              busy;
  logic              overflow;

  modport master (
    output rx_data, rx_rdy, img_ack, core_done, rd_addr,
    input  img_valid, rd_data, busy, overflow
  );

  modport slave (
    input  rx_data, rx_rdy, img_ack, core_done, rd_addr,
    output img_valid, rd_data, busy, overflow
  );
endinterface

// File: rtl/snn_input_dbuf.sv
// rtl/snn_input_dbuf.sv - ping-pong 1-bit-per-pixel image buffer between the UART receiver and snn_core
// One bank loads from UART bytes while the core reads the other through a 1-cycle bit port.
module snn_input_dbuf #(
  parameter int NUM_PIX = 784,
  parameter int BYTE_W  = 8,
  parameter int ADDR_W  = 10
) (
  input logic            clk,
  input logic            rst_n,
  snn_input_dbuf_if.slave bus
);

  localparam int NUM_BYTES = NUM_PIX / BYTE_W;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W + 1)'(NUM_PIX);

  typedef enum logic {RD_IDLE, RD_BUSY} rd_state_e;

  rd_state_e         state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]        full_q, full_d;
  logic              rd_bank_q, rd_bank_d;
  logic              img_valid_q, img_valid_d;
  logic              rd_data_q, rd_data_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        claim_mask;

  logic [NUM_PIX-1:0] bank0_q, bank1_q;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_base;

  // A full bank is never written, so the bank under read is never disturbed.
  assign wr_en   = bus.rx_rdy && !full_q[wr_bank_q];
  assign wr_base = ADDR_W'(byte_cnt_q) * ADDR_W'(BYTE_W);

  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    byte_cnt_d  = byte_cnt_q;
    overflow_d  = overflow_q;
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    claim_mask  = 2'b00;
    img_valid_d = 1'b0;
    rd_data_d   = 1'b0;

    if (bus.rx_rdy) begin
      if (full_q[wr_bank_q]) begin
        overflow_d = 1'b1;
      end else if (byte_cnt_q == LAST_BYTE) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        byte_cnt_d        = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end

    case (state_q)
      RD_IDLE: begin
        // With both banks full the write pointer sits on the older image.
        if (bus.img_ack && img_valid_q) begin
          rd_bank_d = full_q[wr_bank_q] ? wr_bank_q : ~wr_bank_q;
          state_d   = RD_BUSY;
        end
      end
      RD_BUSY: begin
        if (bus.core_done) begin
          full_d[rd_bank_q] = 1'b0;
          state_d           = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase

    if (state_d == RD_BUSY) begin
      claim_mask = rd_bank_d ? 2'b10 : 2'b01;
    end
    img_valid_d = |(full_d & ~claim_mask);

    if ({1'b0, bus.rd_addr} < PIX_LIMIT) begin
      rd_data_d = rd_bank_q ? bank1_q[bus.rd_addr] : bank0_q[bus.rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RD_IDLE;
      wr_bank_q   <= 1'b0;
      byte_cnt_q  <= '0;
      full_q      <= 2'b00;
      rd_bank_q   <= 1'b0;
      img_valid_q <= 1'b0;
      rd_data_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      byte_cnt_q  <= byte_cnt_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      img_valid_q <= img_valid_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Pixel storage is left uncleared; cleared full flags make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank_q) begin
        bank1_q[wr_base +: BYTE_W] <= bus.rx_data;
      end else begin
        bank0_q[wr_base +: BYTE_W] <= bus.rx_data;
      end
    end
  end

  assign bus.img_valid = img_valid_q;
  assign bus.busy      = (state_q == RD_BUSY);
  assign bus.rd_data   = rd_data_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_snn_input_dbuf.sv
// tb/tb_snn_input_dbuf.sv - scoreboard bench for snn_input_dbuf against an image-queue reference model
module tb_snn_input_dbuf;

  localparam int NUM_PIX   = 784;
  localparam int BYTE_W    = 8;
  localparam int ADDR_W    = 10;
  localparam int NUM_BYTES = NUM_PIX / BYTE_W;

  typedef logic [NUM_PIX-1:0] img_t;
  typedef struct {
    bit   rd_chk;
    logic rd;
    logic v;
    logic b;
    logic o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_input_dbuf_if #(.BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) bus ();

  snn_input_dbuf #(.NUM_PIX(NUM_PIX), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference model: completed images wait in arrival order; at most two images are held.
  img_t ready_q[$];
  img_t cur_img;
  img_t claimed_img;
  bit   claimed;
  bit   m_valid;
  bit   m_ovf;
  bit   first_phase;
  int   cnt;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    ready_q.delete();
    claimed     = 1'b0;
    m_valid     = 1'b0;
    m_ovf       = 1'b0;
    first_phase = 1'b1;
    cnt         = 0;
  endtask

  task automatic step(input bit rdy, input logic [7:0] data, input bit ack, input bit done, input int addr);
    exp_t e;
    img_t head;
    bit   complete;
    complete = 1'b0;
    @(negedge clk);
    bus.rx_rdy    = rdy;
    bus.rx_data   = data;
    bus.img_ack   = ack;
    bus.core_done = done;
    bus.rd_addr   = addr[ADDR_W-1:0];

    e.rd_chk = 1'b0;
    e.rd     = 1'b0;
    if (claimed) begin
      e.rd_chk = 1'b1;
      e.rd     = (addr < NUM_PIX) ? claimed_img[addr] : 1'b0;
    end else if (first_phase && ready_q.size() > 0) begin
      // Before the first claim after reset the read port looks at the first image loaded.
      head     = ready_q[0];
      e.rd_chk = 1'b1;
      e.rd     = (addr < NUM_PIX) ? head[addr] : 1'b0;
    end

    if (rdy) begin
      if (ready_q.size() + int'(claimed) < 2) begin
        cur_img[cnt*BYTE_W +: BYTE_W] = data;
        cnt++;
        if (cnt == NUM_BYTES) begin
          complete = 1'b1;
          cnt      = 0;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end

    if (claimed) begin
      if (done) claimed = 1'b0;
    end else if (ack && m_valid) begin
      claimed_img = ready_q.pop_front();
      claimed     = 1'b1;
      first_phase = 1'b0;
    end
    if (complete) ready_q.push_back(cur_img);
    m_valid = (ready_q.size() > 0);

    e.v = m_valid;
    e.b = claimed;
    e.o = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.rx_rdy    = 1'b0;
    bus.rx_data   = '0;
    bus.img_ack   = 1'b0;
    bus.core_done = 1'b0;
    bus.rd_addr   = '0;
    #1;
    chk("reset_img_valid", bus.img_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_overflow", bus.overflow, 1'b0);
    chk("reset_rd_data", bus.rd_data, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_bytes(input int n, input bit rnd, input logic [7:0] val);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) step(1'b0, 8'h00, 1'b0, 1'b0, $urandom_range(1023));
      step(1'b1, rnd ? 8'($urandom) : val, 1'b0, 1'b0, $urandom_range(NUM_PIX - 1));
    end
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) step(1'b0, 8'h00, 1'b0, 1'b0, a);
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        if (m.rd_chk) chk("rd_data", bus.rd_data, m.rd);
        chk("img_valid", bus.img_valid, m.v);
        chk("busy", bus.busy, m.b);
        chk("overflow", bus.overflow, m.o);
      end
    end
  end

  initial begin : driver
    checks   = 0;
    failures = 0;
    model_reset();
    bus.rx_rdy    = 1'b0;
    bus.rx_data   = '0;
    bus.img_ack   = 1'b0;
    bus.core_done = 1'b0;
    bus.rd_addr   = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Load an A5 image and read its first byte back before any claim.
    send_bytes(NUM_BYTES, 1'b0, 8'hA5);
    read_range(0, 9);

    // Claim it, load an all-ones image behind it, then swap.
    step(1'b0, 8'h00, 1'b1, 1'b0, 0);
    send_bytes(NUM_BYTES, 1'b0, 8'hFF);
    read_range(0, 9);
    step(1'b0, 8'h00, 1'b0, 1'b1, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 0);
    read_range(0, 15);

    // Fill both banks without a claim, overflow, then refill the released bank.
    step(1'b0, 8'h00, 1'b0, 1'b1, 0);
    send_bytes(2 * NUM_BYTES, 1'b1, 8'h00);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 3);
    read_range(100, 103);
    step(1'b0, 8'h00, 1'b1, 1'b0, 0);
    read_range(0, 3);
    step(1'b0, 8'h00, 1'b0, 1'b1, 0);
    send_bytes(NUM_BYTES, 1'b1, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 0);
    read_range(0, 7);

    // Final byte of bank 1 lands on the same cycle as core_done for bank 0.
    do_reset();
    send_bytes(NUM_BYTES, 1'b1, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 0);
    send_bytes(NUM_BYTES - 1, 1'b1, 8'h00);
    step(1'b1, 8'($urandom), 1'b0, 1'b1, 5);
    step(1'b0, 8'h00, 1'b0, 1'b0, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 0);
    read_range(770, 783);

    // Reset in the middle of an image, then a fresh image.
    do_reset();
    send_bytes(40, 1'b1, 8'h00);
    do_reset();
    send_bytes(NUM_BYTES, 1'b1, 8'h00);
    read_range(0, 3);
    step(1'b0, 8'h00, 1'b1, 1'b0, 0);

    // Out-of-range reads and repeated acks while busy.
    for (int i = 0; i < 24; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 784 + $urandom_range(239));
    step(1'b0, 8'h00, 1'b1, 1'b0, 1023);
    read_range(0, 7);

    // Randomized traffic.
    for (int i = 0; i < 5000; i++) begin
      step(1'($urandom_range(1)), 8'($urandom), ($urandom_range(15) == 0), ($urandom_range(19) == 0),
           $urandom_range(1023));
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drain", (exp_q.size() == 0), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
